// File: rtl/legv8_multicycle_controller.sv
// Multi-cycle LEGv8 control unit: fetches from a synchronous instruction ROM,
// decodes, drives the datapath ControlWord/constant and owns the PC.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | PC presented to ROM, NOP word, waits for run
// DECODE | ROM data latched into IR, NOP word
// EXEC   | decoded word driven; R-type/STUR/CBZ/B retire here
// MEM_RD | load address held on the bus, no enables
// MEM_WB | memory drives bus, Rt written, load retires
// HALT   | unknown opcode seen; NOP word until reset
module legv8_multicycle_controller #(
    parameter logic [4:0]  FS_ADD   = 5'b01000,
    parameter logic [4:0]  FS_SUB   = 5'b01010,
    parameter logic [4:0]  FS_AND   = 5'b00000,
    parameter logic [4:0]  FS_ORR   = 5'b00100,
    parameter logic [4:0]  FS_EOR   = 5'b01100,
    parameter logic [4:0]  FS_PASSA = 5'b11100,
    parameter int          Z_BIT    = 0,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic [63:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic [3:0]  status,
    output logic [34:0] ControlWord,
    output logic [63:0] constant,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WB = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic        ir_load;

    logic [4:0]  rn, rm, rd;
    logic [10:0] opcode;
    logic        is_cb, is_b;
    logic [63:0] imm_cb, imm_b;

    logic [4:0]  sa, sb, da, fs;
    logic        reg_write, mem_write, c0, en_mem, en_alu;
    logic        status_unused;

    assign rn     = ir_q[9:5];
    assign rm     = ir_q[20:16];
    assign rd     = ir_q[4:0];
    assign opcode = ir_q[31:21];
    assign is_cb  = (ir_q[31:24] == 8'b10110100);
    assign is_b   = (ir_q[31:26] == 6'b000101);
    assign imm_cb = {{45{ir_q[23]}}, ir_q[23:5]};
    assign imm_b  = {{38{ir_q[25]}}, ir_q[25:0]};

    // Only the zero flag steers branches; the other flags are informational.
    assign status_unused = ^status;

    // State, PC and IR registers; reset drops straight back to FETCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) ir_q <= instr_data;
        end
    end

    // Next-state, next-PC and control word decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_load   = 1'b0;
        sa        = 5'd0;
        sb        = 5'd0;
        da        = 5'd0;
        fs        = 5'd0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        c0        = 1'b0;
        en_mem    = 1'b0;
        en_alu    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
                    opcode == OP_ORR || opcode == OP_EOR) begin
                    sa        = rn;
                    sb        = rm;
                    da        = rd;
                    reg_write = 1'b1;
                    en_alu    = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    case (opcode)
                        OP_ADD:  fs = FS_ADD;
                        OP_SUB:  begin fs = FS_SUB; c0 = 1'b1; end
                        OP_AND:  fs = FS_AND;
                        OP_ORR:  fs = FS_ORR;
                        default: fs = FS_EOR;
                    endcase
                end else if (opcode == OP_STUR) begin
                    sa        = rn;
                    sb        = rd;
                    fs        = FS_PASSA;
                    mem_write = 1'b1;
                    pc_d      = pc_q + 64'd4;
                end else if (opcode == OP_LDUR) begin
                    sa      = rn;
                    fs      = FS_PASSA;
                    state_d = S_MEM_RD;
                end else if (is_cb) begin
                    sa = rd;
                    fs = FS_PASSA;
                    if (status[Z_BIT]) pc_d = pc_q + {imm_cb[61:0], 2'b00};
                    else               pc_d = pc_q + 64'd4;
                end else if (is_b) begin
                    pc_d = pc_q + {imm_b[61:0], 2'b00};
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM_RD: begin
                sa      = rn;
                fs      = FS_PASSA;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                sa        = rn;
                fs        = FS_PASSA;
                da        = rd;
                reg_write = 1'b1;
                en_mem    = 1'b1;
                pc_d      = pc_q + 64'd4;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign ControlWord = {10'b0, sa, sb, da, reg_write, mem_write, fs, c0, en_mem, en_alu};
    assign constant    = is_cb ? imm_cb : (is_b ? imm_b : 64'h0);
    assign instr_addr  = pc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// Directed bench for the LEGv8 controller: a small ROM program is stepped
// through while per-cycle expectations are queued and checked on negedge.
module tb_legv8_multicycle_controller;

    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01010;
    localparam logic [4:0] FS_PASSA = 5'b11100;
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, MR = 3'd3, WB = 3'd4, H = 3'd7;

    logic        clock, reset, run;
    logic [63:0] instr_addr;
    logic [31:0] instr_data;
    logic [3:0]  status;
    logic [34:0] ControlWord;
    logic [63:0] constant;
    logic        halted;
    logic [2:0]  state;

    legv8_multicycle_controller dut (
        .clock(clock), .reset(reset), .run(run),
        .instr_addr(instr_addr), .instr_data(instr_data), .status(status),
        .ControlWord(ControlWord), .constant(constant),
        .halted(halted), .state(state)
    );

    typedef struct {
        logic [2:0]  st;
        logic [34:0] cw;
        logic [63:0] pc;
        logic [63:0] k;
        logic        h;
    } exp_t;

    exp_t        sbq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          rec_id   = 0;
    logic [63:0] k_prev;
    logic [31:0] rom [0:15];
    logic        done = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clock) instr_data <= rom[instr_addr[5:2]];

    function automatic logic [34:0] cw(input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic rw,
                                       input logic mw, input logic [4:0] fs,
                                       input logic c0, input logic enm,
                                       input logic ena);
        return {10'b0, sa, sb, da, rw, mw, fs, c0, enm, ena};
    endfunction

    task automatic push(input logic [2:0] st, input logic [34:0] c,
                        input logic [63:0] pc, input logic [63:0] k, input logic h);
        exp_t e;
        e.st = st; e.cw = c; e.pc = pc; e.k = k; e.h = h;
        sbq.push_back(e);
    endtask

    // FETCH and DECODE of an instruction still show the previous IR's constant.
    task automatic fd(input logic [63:0] pc);
        push(F, 35'd0, pc, k_prev, 1'b0);
        push(D, 35'd0, pc, k_prev, 1'b0);
    endtask

    task automatic check_now();
        exp_t e;
        rec_id++;
        n_assert++;
        assert (sbq.size() != 0) else begin
            n_fail++;
            $error("FAIL rec%0d queue observed=empty expected=entry", rec_id);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            n_assert++;
            assert (state === e.st) else begin
                n_fail++;
                $error("FAIL rec%0d state observed=%0d expected=%0d", rec_id, state, e.st);
            end
            n_assert++;
            assert (ControlWord === e.cw) else begin
                n_fail++;
                $error("FAIL rec%0d ControlWord observed=%h expected=%h", rec_id, ControlWord, e.cw);
            end
            n_assert++;
            assert (instr_addr === e.pc) else begin
                n_fail++;
                $error("FAIL rec%0d pc observed=%h expected=%h", rec_id, instr_addr, e.pc);
            end
            n_assert++;
            assert (constant === e.k) else begin
                n_fail++;
                $error("FAIL rec%0d constant observed=%h expected=%h", rec_id, constant, e.k);
            end
            n_assert++;
            assert (halted === e.h) else begin
                n_fail++;
                $error("FAIL rec%0d halted observed=%b expected=%b", rec_id, halted, e.h);
            end
        end
    endtask

    task automatic drain();
        while (sbq.size() != 0) begin
            @(negedge clock);
            check_now();
        end
    endtask

    // EN_Mem and EN_ALU must never share the bus.
    always @(negedge clock) begin
        if (!done) begin
            n_assert++;
            assert (!(ControlWord[1] === 1'b1 && ControlWord[0] === 1'b1)) else begin
                n_fail++;
                $error("FAIL bus_excl observed=%b%b expected=not_both", ControlWord[1], ControlWord[0]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0] = 32'h8B020023;   // ADD  X3,X1,X2
        rom[1] = 32'hCB0500A5;   // SUB  X5,X5,X5
        rom[2] = 32'hB4000065;   // CBZ  X5,#3
        rom[3] = 32'h00000000;   // illegal -> HALT
        rom[4] = 32'h17FFFFFE;   // B    #-2
        rom[5] = 32'hF8400087;   // LDUR X7,[X4]
        rom[6] = 32'hF8000089;   // STUR X9,[X4]
        rom[7] = 32'h17FFFFFD;   // B    #-3

        reset = 1'b1; run = 1'b0; status = 4'h0; k_prev = 64'h0;
        @(negedge clock);
        push(F, 35'd0, 64'h0, 64'h0, 1'b0);
        check_now();
        run = 1'b1;
        @(posedge clock); #1 reset = 1'b0;

        fd(0);  push(E, cw(1, 2, 3, 1, 0, FS_ADD, 0, 0, 1), 0, 0, 0);  k_prev = 0;
        fd(4);  push(E, cw(5, 5, 5, 1, 0, FS_SUB, 1, 0, 1), 4, 0, 0);  k_prev = 0;
        drain();
        status = 4'b0001;
        fd(8);  push(E, cw(5, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 8, 64'd3, 0);  k_prev = 64'd3;
        fd(20); push(E,  cw(4, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 20, 0, 0);
                push(MR, cw(4, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 20, 0, 0);
                push(WB, cw(4, 0, 7, 1, 0, FS_PASSA, 0, 1, 0), 20, 0, 0);  k_prev = 0;
        fd(24); push(E, cw(4, 9, 0, 0, 1, FS_PASSA, 0, 0, 0), 24, 0, 0);
        fd(28); push(E, 35'd0, 28, 64'hFFFF_FFFF_FFFF_FFFD, 0);  k_prev = 64'hFFFF_FFFF_FFFF_FFFD;
        fd(16); push(E, 35'd0, 16, 64'hFFFF_FFFF_FFFF_FFFE, 0);  k_prev = 64'hFFFF_FFFF_FFFF_FFFE;
        drain();
        status = 4'b0000;
        fd(8);  push(E, cw(5, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 8, 64'd3, 0);  k_prev = 64'd3;
        fd(12); push(E, 35'd0, 12, 0, 0);
        for (int i = 0; i < 3; i++) push(H, 35'd0, 12, 0, 1'b1);
        drain();

        // Reset out of HALT, then hold run low in FETCH.
        reset = 1'b1; #1;
        push(F, 35'd0, 0, 0, 0);
        check_now();
        run = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) push(F, 35'd0, 0, 0, 0);
        drain();

        // Run up to the load and reset it while in MEM_RD.
        run = 1'b1; k_prev = 0;
        push(D, 35'd0, 0, 0, 0);
        push(E, cw(1, 2, 3, 1, 0, FS_ADD, 0, 0, 1), 0, 0, 0);
        fd(4);  push(E, cw(5, 5, 5, 1, 0, FS_SUB, 1, 0, 1), 4, 0, 0);
        drain();
        status = 4'b0001;
        fd(8);  push(E, cw(5, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 8, 64'd3, 0);  k_prev = 64'd3;
        fd(20); push(E,  cw(4, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 20, 0, 0);
                push(MR, cw(4, 0, 0, 0, 0, FS_PASSA, 0, 0, 0), 20, 0, 0);
        drain();
        reset = 1'b1; #1;
        push(F, 35'd0, 0, 0, 0);
        check_now();
        run = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) push(F, 35'd0, 0, 0, 0);
        drain();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
